fifo_frame_serializer: RTL and testbench

Downstream consumer of the postprocess flip-flop FIFO, which has push/pop/empty/full control and combinational read data. It pops wide FFT result words from that FIFO and serializes each one into `ratio` narrow slices on a valid/ready output stream. It also marks frame boundaries with `out_last` after every `frame_len` words. It sits between the FIFO and the output/readout logic and runs at full throughput, with no bubble between words, while `out_ready` stays high.

---
 rtl/postprocess_pkg.sv | 16 +
 rtl/wrap_counter.sv | 32 +++
 rtl/fifo_frame_serializer.sv | 132 +++++++++++++
 tb/tb_fifo_frame_serializer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/postprocess_pkg.sv
// Shared definitions for the postprocess readout path.
// Holds the serializer state encoding and the default geometry constants, so
// that the FIFO instance and the serializer agree on word width, slicing and frame length.
package postprocess_pkg;

   // Serializer word-holding state: IDLE = no word latched, HOLD = word being sliced out.
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } hold_state_t;

   localparam int PP_IN_WIDTH  = 32;
   localparam int PP_RATIO     = 4;
   localparam int PP_FRAME_LEN = 256;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-limit counter: counts inc pulses 0..limit-1 and wraps to 0.
// Latency: cnt updates on the clock after inc; wrap is combinational (inc on the last count).
// Backpressure: none; the caller gates inc. clr is synchronous and overrides inc.
// Ports: clk, rstn (async active-low), inc, clr, cnt (current count), wrap (terminal-count pulse).
module wrap_counter #(
   parameter int limit = 4,
   localparam int cnt_w = (limit < 2) ? 1 : $clog2(limit)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   input  logic             clr,
   output logic [cnt_w-1:0] cnt,
   output logic             wrap
);

   localparam logic [cnt_w-1:0] cnt_max = cnt_w'(limit - 1);

   assign wrap = inc & (cnt == cnt_max);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         // Explicit wrap so non-power-of-two limits work.
         cnt <= wrap ? '0 : cnt + cnt_w'(1);
      end
   end

endmodule

// File: rtl/fifo_frame_serializer.sv
// Pops wide words from a flip-flop FIFO and streams each as ratio slices (LSB first), marking frame ends.
// Latency: pop in cycle t from IDLE gives slice 0 valid in t+1; back-to-back words have no bubble.
// Backpressure: out_ready low freezes the current slice and blocks the next pop; held words are never dropped.
// Ports: clk, rstn (async active-low); FIFO side fifo_empty, fifo_rd_data, fifo_pop (combinational);
//        clear (synchronous abort); stream out_valid/out_ready/out_data/out_last; frame_done (registered pulse).
module fifo_frame_serializer
   import postprocess_pkg::*;
#(
   parameter int in_width  = PP_IN_WIDTH,
   parameter int ratio     = PP_RATIO,
   parameter int frame_len = PP_FRAME_LEN
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      fifo_empty,
   input  logic [in_width-1:0]       fifo_rd_data,
   output logic                      fifo_pop,
   input  logic                      clear,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [in_width/ratio-1:0] out_data,
   output logic                      out_last,
   output logic                      frame_done
);

   localparam int out_width = in_width / ratio;
   localparam int slice_w   = $clog2(ratio);
   localparam int word_w    = $clog2(frame_len);
   localparam logic [slice_w-1:0] slice_max = slice_w'(ratio - 1);
   localparam logic [word_w-1:0]  word_max  = word_w'(frame_len - 1);

   // Elaboration-time geometry checks.
   if (in_width % ratio != 0) begin : g_bad_width
      $error("fifo_frame_serializer: in_width must be divisible by ratio");
   end
   if (ratio < 2) begin : g_bad_ratio
      $error("fifo_frame_serializer: ratio must be >= 2");
   end
   if (frame_len < 2) begin : g_bad_frame
      $error("fifo_frame_serializer: frame_len must be >= 2");
   end

   hold_state_t           state_q, state_d;
   logic [in_width-1:0]   hold_q;
   logic [slice_w-1:0]    slice_cnt;
   logic [word_w-1:0]     word_cnt;
   logic                  held;
   logic                  beat;
   logic                  slice_last;
   logic                  slice_wrap;
   logic                  word_wrap;
   logic                  frame_done_q;

   assign held       = (state_q == HOLD);
   assign beat       = held & out_ready;
   assign slice_last = (slice_cnt == slice_max);

   // A new word is taken when idle, or on the final-slice beat so words abut.
   assign fifo_pop   = !clear & !fifo_empty & (!held | (beat & slice_last));

   assign out_valid  = held;
   assign out_last   = held & slice_last & (word_cnt == word_max);
   assign frame_done = frame_done_q;

   always_comb begin
      out_data = hold_q[out_width-1:0];
      for (int i = 0; i < ratio; i++) begin
         if (slice_cnt == slice_w'(i)) begin
            out_data = hold_q[i*out_width +: out_width];
         end
      end
   end

   // Slice position; also zeroed on a load from IDLE so a fresh word starts at slice 0.
   wrap_counter #(.limit(ratio)) u_slice_cnt (
      .clk  (clk),
      .rstn (rstn),
      .inc  (beat & !clear),
      .clr  (clear | (fifo_pop & !held)),
      .cnt  (slice_cnt),
      .wrap (slice_wrap)
   );

   // Word-in-frame position; its wrap is exactly an accepted out_last beat.
   wrap_counter #(.limit(frame_len)) u_word_cnt (
      .clk  (clk),
      .rstn (rstn),
      .inc  (slice_wrap),
      .clr  (clear),
      .cnt  (word_cnt),
      .wrap (word_wrap)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else if (fifo_pop) begin
         state_d = HOLD;
      end else if (slice_wrap) begin
         // Last slice accepted and nothing to reload.
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_q <= '0;
      end else if (fifo_pop) begin
         hold_q <= fifo_rd_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frame_done_q <= 1'b0;
      end else if (clear) begin
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= word_wrap;
      end
   end

endmodule

// File: tb/tb_fifo_frame_serializer.sv
// Directed bench for fifo_frame_serializer with in_width=32, ratio=4, frame_len=4.
// A small array-backed FIFO model feeds the DUT; inputs change and outputs are sampled #1 after the falling edge.
// Ports covered: all DUT ports.
module tb_fifo_frame_serializer;

   localparam int IW = 32;
   localparam int R  = 4;
   localparam int FL = 4;
   localparam int OW = IW / R;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          clear = 1'b0;
   logic          out_ready = 1'b0;
   logic          fifo_empty;
   logic          fifo_pop;
   logic          out_valid;
   logic          out_last;
   logic          frame_done;
   logic [IW-1:0] fifo_rd_data;
   logic [OW-1:0] out_data;

   logic [IW-1:0] fmem [0:15];
   logic [4:0]    wr_ptr = '0;
   logic [4:0]    rd_ptr = '0;

   int n_cmp = 0;
   int n_err = 0;

   logic [IW-1:0] bw [2] = '{32'h44332211, 32'h88776655};
   logic [IW-1:0] fw [5] = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130, 32'h43424140};
   logic [IW-1:0] xw [6] = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 32'hD3D2D1D0, 32'hE3E2E1E0, 32'hF3F2F1F0};
   logic [IW-1:0] ew [3] = '{32'h5A4B3C2D, 32'h01EFCDAB, 32'h7F6E5D4C};

   always #5 clk = ~clk;

   assign fifo_empty   = (wr_ptr == rd_ptr);
   assign fifo_rd_data = fmem[rd_ptr[3:0]];

   always @(posedge clk) begin
      if (fifo_pop) rd_ptr <= rd_ptr + 5'd1;
   end

   fifo_frame_serializer #(.in_width(IW), .ratio(R), .frame_len(FL)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_pop     (fifo_pop),
      .clear        (clear),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .frame_done   (frame_done)
   );

   task automatic push(input logic [IW-1:0] w);
      fmem[wr_ptr[3:0]] = w;
      wr_ptr = wr_ptr + 5'd1;
   endtask

   function automatic logic [OW-1:0] sl(input logic [IW-1:0] w, input int i);
      logic [IW-1:0] t;
      t = w >> (OW * i);
      return t[OW-1:0];
   endfunction

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b want 0", out_last); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", out_data); end
      n_cmp++; if (fifo_pop !== 1'b0) begin n_err++; $display("FAIL rst_pop_empty: got %b want 0", fifo_pop); end
      push(32'hCAFEF00D);
      #1;
      n_cmp++; if (fifo_pop !== 1'b1) begin n_err++; $display("FAIL rst_pop_nonempty: got %b want 1", fifo_pop); end
      clear = 1'b1;
      #1;
      n_cmp++; if (fifo_pop !== 1'b0) begin n_err++; $display("FAIL rst_pop_clear: got %b want 0", fifo_pop); end
      clear = 1'b0;
      wr_ptr = rd_ptr;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_single_word();
      logic [IW-1:0] w;
      w = 32'hDDCCBBAA;
      @(negedge clk);
      out_ready = 1'b1;
      push(w);
      #1;
      n_cmp++; if (fifo_pop !== 1'b1) begin n_err++; $display("FAIL single_pop: got %b want 1", fifo_pop); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_t: got %b want 0", out_valid); end
      for (int i = 0; i < R; i++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== sl(w, i)) begin
            n_err++; $display("FAIL single_slice%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, sl(w, i));
         end
      end
      @(negedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_end: got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      int  ewd [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
      int  esl [12] = '{0, 0, 1, 1, 1, 1, 2, 3, 0, 1, 2, 3};
      logic erd [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) begin
            push(bw[0]);
            push(bw[1]);
         end
         out_ready = erd[c];
         #1;
         n_cmp++;
         if (fifo_pop !== (c == 0 || c == 7)) begin
            n_err++; $display("FAIL bp_pop c=%0d: got %b want %b", c, fifo_pop, (c == 0 || c == 7));
         end
         if (c >= 1) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== sl(bw[ewd[c]], esl[c])) begin
               n_err++; $display("FAIL bp_data c=%0d: got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, sl(bw[ewd[c]], esl[c]));
            end
         end
      end
      @(negedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_end: got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      logic [IW-1:0] a;
      logic [IW-1:0] b;
      logic [IW-1:0] w;
      a = 32'h0A0B0C0D;
      b = 32'h1A1B1C1D;
      // Three words already streamed, so a is the last word of a frame.
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c == 0) begin
            push(a);
            push(b);
         end
         out_ready = 1'b1;
         #1;
         if (c >= 1) begin
            w = (c <= 4) ? a : b;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== sl(w, (c - 1) % 4)) begin
               n_err++; $display("FAIL rm_data c=%0d: got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, sl(w, (c - 1) % 4));
            end
            n_cmp++;
            if (out_last !== (c == 4)) begin
               n_err++; $display("FAIL rm_last c=%0d: got %b want %b", c, out_last, (c == 4));
            end
            n_cmp++;
            if (frame_done !== (c == 5)) begin
               n_err++; $display("FAIL rm_frame_done c=%0d: got %b want %b", c, frame_done, (c == 5));
            end
         end
      end
      @(negedge clk);
      rstn = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rm_last_rst: got %b want 0", out_last); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rm_frame_done_rst: got %b want 0", frame_done); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rm_data_rst: got %h want 00", out_data); end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_full_frame();
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         if (c == 0) begin
            for (int k = 0; k < 5; k++) push(fw[k]);
         end
         out_ready = 1'b1;
         #1;
         n_cmp++;
         if (fifo_pop !== (c % 4 == 0 && c <= 16)) begin
            n_err++; $display("FAIL ff_pop c=%0d: got %b want %b", c, fifo_pop, (c % 4 == 0 && c <= 16));
         end
         if (c >= 1) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== sl(fw[(c - 1) / 4], (c - 1) % 4)) begin
               n_err++; $display("FAIL ff_data c=%0d: got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, sl(fw[(c - 1) / 4], (c - 1) % 4));
            end
            n_cmp++;
            if (out_last !== (c == 16)) begin
               n_err++; $display("FAIL ff_last c=%0d: got %b want %b", c, out_last, (c == 16));
            end
            n_cmp++;
            if (frame_done !== (c == 17)) begin
               n_err++; $display("FAIL ff_frame_done c=%0d: got %b want %b", c, frame_done, (c == 17));
            end
         end
      end
      @(negedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ff_valid_end: got %b want 0", out_valid); end
   endtask

   task automatic test_clear();
      logic [IW-1:0] w;
      int            s;
      for (int c = 0; c <= 25; c++) begin
         @(negedge clk);
         if (c == 0) begin
            for (int k = 0; k < 6; k++) push(xw[k]);
         end
         out_ready = 1'b1;
         clear = (c == 8);
         #1;
         n_cmp++;
         if (fifo_pop !== (c == 0 || c == 4 || c == 9 || c == 13 || c == 17 || c == 21)) begin
            n_err++; $display("FAIL clr_pop c=%0d: got %b", c, fifo_pop);
         end
         if (c == 9) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid_after: got %b want 0", out_valid); end
         end else if (c >= 1) begin
            w = (c <= 8) ? xw[(c - 1) / 4] : xw[2 + (c - 10) / 4];
            s = (c <= 8) ? (c - 1) % 4 : (c - 10) % 4;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== sl(w, s)) begin
               n_err++; $display("FAIL clr_data c=%0d: got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, sl(w, s));
            end
            n_cmp++;
            if (out_last !== (c == 25)) begin
               n_err++; $display("FAIL clr_last c=%0d: got %b want %b", c, out_last, (c == 25));
            end
         end
      end
      @(negedge clk);
      clear = 1'b0;
      #1;
      n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL clr_frame_done: got %b want 1", frame_done); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid_end: got %b want 0", out_valid); end
   endtask

   task automatic test_empty_boundary();
      logic          ev;
      logic [IW-1:0] w;
      int            s;
      for (int c = 0; c <= 16; c++) begin
         @(negedge clk);
         if (c == 0) begin
            push(ew[0]);
            push(ew[1]);
         end
         if (c == 11) push(ew[2]);
         out_ready = 1'b1;
         #1;
         n_cmp++;
         if (fifo_pop !== (c == 0 || c == 4 || c == 11)) begin
            n_err++; $display("FAIL eb_pop c=%0d: got %b want %b", c, fifo_pop, (c == 0 || c == 4 || c == 11));
         end
         ev = (c >= 1 && c <= 8) || (c >= 12 && c <= 15);
         n_cmp++;
         if (out_valid !== ev) begin
            n_err++; $display("FAIL eb_valid c=%0d: got %b want %b", c, out_valid, ev);
         end
         if (ev) begin
            w = (c <= 8) ? ew[(c - 1) / 4] : ew[2];
            s = (c <= 8) ? (c - 1) % 4 : c - 12;
            n_cmp++;
            if (out_data !== sl(w, s)) begin
               n_err++; $display("FAIL eb_data c=%0d: got %h want %h", c, out_data, sl(w, s));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_backpressure();
      test_reset_mid();
      test_full_frame();
      test_clear();
      test_empty_boundary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
